// File: rtl/ledtimer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ledtimer -- free-running interval timer for the lab board.
//
// A prescaler divides mclk down to a tick. The tick period is
// BASE_DIV >> swt mclk cycles. Each tick advances an 8-bit binary LED count
// and a 4-digit BCD count. The BCD count is shown on a multiplexed 4-digit
// common-anode seven-segment display.
//
// Parameters:
//   BASE_DIV     mclk cycles per tick at swt=00 (multiple of 8, >= 8)
//   REFRESH_DIV  mclk cycles each display digit stays enabled (>= 1)
//
// Ports:
//   mclk   in   1  system clock, all logic on the rising edge
//   rst_n  in   1  synchronous active-low reset
//   swt    in   2  rate select (00 slowest ... 11 fastest, x8)
//   led    out  8  binary tick count, registered
//   seg    out  7  segment drive, active-low, seg[6]=g ... seg[0]=a, registered
//   an     out  4  digit enable, active-low, an[0]=ones digit, registered
// -----------------------------------------------------------------------------
module ledtimer #(
    parameter int BASE_DIV    = 10_000_000,
    parameter int REFRESH_DIV = 10_000
) (
    input  logic       mclk,
    input  logic       rst_n,
    input  logic [1:0] swt,
    output logic [7:0] led,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int PW = $clog2(BASE_DIV);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    // Terminal prescaler value for each rate; each fits in PW bits because
    // the largest is BASE_DIV-1.
    localparam logic [PW-1:0] TERM_00 = PW'(BASE_DIV - 1);
    localparam logic [PW-1:0] TERM_01 = PW'(BASE_DIV / 2 - 1);
    localparam logic [PW-1:0] TERM_10 = PW'(BASE_DIV / 4 - 1);
    localparam logic [PW-1:0] TERM_11 = PW'(BASE_DIV / 8 - 1);
    localparam logic [RW-1:0] RTERM   = RW'(REFRESH_DIV - 1);

    localparam logic [6:0] GLYPH_ZERO = 7'b1000000;
    localparam logic [3:0] AN_IDX0    = 4'b1110;

    // Active-low gfedcba glyph for one BCD digit; non-BCD codes blank.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    // One-cold digit enable for a scan index.
    function automatic logic [3:0] an_decode(input logic [1:0] i);
        case (i)
            2'd0:    an_decode = 4'b1110;
            2'd1:    an_decode = 4'b1101;
            2'd2:    an_decode = 4'b1011;
            default: an_decode = 4'b0111;
        endcase
    endfunction

    // State registers
    logic [PW-1:0]      pre;
    logic [1:0]         swt_q;
    logic [3:0][3:0]    bcd;      // bcd[0] = ones ... bcd[3] = thousands
    logic [RW-1:0]      rcnt;
    logic [1:0]         idx;

    // Next-state values
    logic [PW-1:0]      pre_next;
    logic [PW-1:0]      term;
    logic               changed;
    logic               tick;
    logic [3:0][3:0]    bcd_next;
    logic               carry;
    logic [RW-1:0]      rcnt_next;
    logic [1:0]         idx_next;

    // Prescaler: a switch change restarts the count and suppresses the tick
    // that would otherwise fall on that edge.
    // NOTE: every signal written in an always_comb gets a default before any
    // conditional assignment, so no path leaves it unassigned (no latch).
    always_comb begin
        term     = TERM_00;
        pre_next = pre + 1'b1;
        case (swt_q)
            2'b00:   term = TERM_00;
            2'b01:   term = TERM_01;
            2'b10:   term = TERM_10;
            default: term = TERM_11;
        endcase
        changed = (swt != swt_q);
        tick    = !changed && (pre == term);
        if (changed || tick) begin
            pre_next = '0;
        end
    end

    // Decimal increment with ripple carry; 9999 wraps to 0000.
    always_comb begin
        bcd_next = bcd;
        carry    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (bcd[i] == 4'd9) begin
                    bcd_next[i] = 4'd0;
                end else begin
                    bcd_next[i] = bcd[i] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
    end

    // Display scan: dwell REFRESH_DIV cycles per digit.
    always_comb begin
        rcnt_next = rcnt + 1'b1;
        idx_next  = idx;
        if (rcnt == RTERM) begin
            rcnt_next = '0;
            idx_next  = idx + 2'd1;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            pre   <= '0;
            swt_q <= swt;
            led   <= 8'h00;
            bcd   <= '0;
            rcnt  <= '0;
            idx   <= 2'd0;
            an    <= AN_IDX0;
            seg   <= GLYPH_ZERO;
        end else begin
            pre   <= pre_next;
            swt_q <= swt;
            if (tick) begin
                led <= led + 8'd1;
                bcd <= bcd_next;
            end
            rcnt  <= rcnt_next;
            idx   <= idx_next;
            // an moves together with the index; seg follows the digit that
            // was selected before this edge, so it trails an by one cycle.
            an    <= an_decode(idx_next);
            seg   <= glyph(bcd[idx]);
        end
    end

endmodule

// File: tb/tb_ledtimer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_ledtimer -- self-checking bench for ledtimer (BASE_DIV=16, REFRESH_DIV=4).
//
// A reference model tracks the number of ticks, the cycles since the last
// prescaler restart and the cycles since reset, and derives led, an and seg
// from those with plain arithmetic. Directed vectors and hand-written
// sequences cover the counting, switch-change, wrap and reset corner cases.
// -----------------------------------------------------------------------------
module tb_ledtimer;

    localparam int BASE_DIV    = 16;
    localparam int REFRESH_DIV = 4;

    logic       mclk  = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] swt   = 2'b00;
    logic [7:0] led;
    logic [6:0] seg;
    logic [3:0] an;

    ledtimer #(
        .BASE_DIV    (BASE_DIV),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .mclk  (mclk),
        .rst_n (rst_n),
        .swt   (swt),
        .led   (led),
        .seg   (seg),
        .an    (an)
    );

    always #5 mclk = ~mclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [6:0] ref_glyph(input int d);
        case (d)
            0:       ref_glyph = 7'b1000000;
            1:       ref_glyph = 7'b1111001;
            2:       ref_glyph = 7'b0100100;
            3:       ref_glyph = 7'b0110000;
            4:       ref_glyph = 7'b0011001;
            5:       ref_glyph = 7'b0010010;
            6:       ref_glyph = 7'b0000010;
            7:       ref_glyph = 7'b1111000;
            8:       ref_glyph = 7'b0000000;
            default: ref_glyph = 7'b0010000;
        endcase
    endfunction

    function automatic int dec_digit(input int value, input int pos);
        int p;
        p = 1;
        for (int k = 0; k < pos; k++) p = p * 10;
        return (value % 10000) / p % 10;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        bit         valid;
        int         ticks;   // total ticks since reset
        int         since;   // cycles since last tick or prescaler restart
        int         cyc;     // cycles since reset release
        logic [1:0] swt_q;
        logic [6:0] seg;
        logic [3:0] an;
    } model_t;

    model_t m = '{valid: 1'b0, ticks: 0, since: 0, cyc: 0, swt_q: 2'b00,
                  seg: 7'h00, an: 4'h0};

    function automatic model_t model_next(input model_t cur, input logic r_n,
                                          input logic [1:0] s);
        model_t n;
        int     idx;
        n = cur;
        if (!r_n) begin
            n.valid = 1'b1;
            n.ticks = 0;
            n.since = 0;
            n.cyc   = 0;
            n.swt_q = s;
            n.seg   = ref_glyph(0);
            n.an    = 4'b1110;
        end else if (cur.valid) begin
            idx   = (cur.cyc / REFRESH_DIV) % 4;
            n.seg = ref_glyph(dec_digit(cur.ticks, idx));
            n.cyc = cur.cyc + 1;
            if (s != cur.swt_q) begin
                n.since = 0;
            end else begin
                n.since = cur.since + 1;
                if (n.since == (BASE_DIV >> cur.swt_q)) begin
                    n.since = 0;
                    n.ticks = cur.ticks + 1;
                end
            end
            n.swt_q = s;
            n.an    = ~(4'b0001 << ((n.cyc / REFRESH_DIV) % 4));
        end
        return n;
    endfunction

    always @(posedge mclk) m <= model_next(m, rst_n, swt);

    always @(negedge mclk) begin
        if (m.valid) begin
            check("model led", {24'd0, led}, m.ticks % 256);
            check("model an",  {28'd0, an},  {28'd0, m.an});
            check("model seg", {25'd0, seg}, {25'd0, m.seg});
        end
    end

    // ---------------- stimulus helpers ----------------
    // Advance n rising edges and return on the following falling edge.
    task automatic run(input int n);
        repeat (n) @(posedge mclk);
        @(negedge mclk);
    endtask

    // Freeze the counters by flipping swt every cycle (each edge is then a
    // switch-change edge) and read each digit position off the display.
    task automatic read_display(input int value, input string tag);
        logic [6:0] got [4];
        logic [3:0] prev_an;
        for (int k = 0; k < 4; k++) got[k] = 'x;
        prev_an = an;
        for (int c = 0; c < 4 * REFRESH_DIV + 4; c++) begin
            swt = (swt == 2'b11) ? 2'b10 : 2'b11;
            run(1);
            for (int k = 0; k < 4; k++) begin
                if (prev_an == ~(4'b0001 << k)) got[k] = seg;
            end
            prev_an = an;
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s digit%0d", tag, k), {25'd0, got[k]},
                  {25'd0, ref_glyph(dec_digit(value, k))});
        end
    endtask

    task automatic do_reset(input logic [1:0] s);
        rst_n = 1'b0;
        swt   = s;
        run(1);
        rst_n = 1'b1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit         rst;    // hold rst_n low for these cycles
        logic [1:0] swt;
        int         n;      // rising edges to apply
        logic [7:0] led;    // expected led afterwards
        bit         disp;   // also check the reset display state
    } vec_t;

    vec_t vecs [9];

    initial begin
        int w;

        // Rate 00: first tick at edge 16, led=5 at edge 80.
        vecs[0] = '{rst: 1, swt: 2'b00, n: 2,  led: 8'd0, disp: 1};
        vecs[1] = '{rst: 0, swt: 2'b00, n: 15, led: 8'd0, disp: 0};
        vecs[2] = '{rst: 0, swt: 2'b00, n: 1,  led: 8'd1, disp: 0};
        vecs[3] = '{rst: 0, swt: 2'b00, n: 64, led: 8'd5, disp: 0};
        // Rate 11 to led=3, then switch to 01: no tick on the change edge,
        // next tick 8 edges later.
        vecs[4] = '{rst: 1, swt: 2'b11, n: 1,  led: 8'd0, disp: 1};
        vecs[5] = '{rst: 0, swt: 2'b11, n: 6,  led: 8'd3, disp: 0};
        vecs[6] = '{rst: 0, swt: 2'b01, n: 1,  led: 8'd3, disp: 0};
        vecs[7] = '{rst: 0, swt: 2'b01, n: 7,  led: 8'd3, disp: 0};
        vecs[8] = '{rst: 0, swt: 2'b01, n: 1,  led: 8'd4, disp: 0};

        for (int i = 0; i < 9; i++) begin
            rst_n = !vecs[i].rst;
            swt   = vecs[i].swt;
            run(vecs[i].n);
            check($sformatf("vec%0d led", i), {24'd0, led}, {24'd0, vecs[i].led});
            if (vecs[i].disp) begin
                check($sformatf("vec%0d an", i),  {28'd0, an},  32'h0000_000E);
                check($sformatf("vec%0d seg", i), {25'd0, seg}, 32'h0000_0040);
            end
        end
        rst_n = 1'b1;

        // LED wrap: 256 ticks at L=2.
        do_reset(2'b11);
        run(512);
        check("wrap led", {24'd0, led}, 32'h00);
        read_display(256, "wrap");

        // Digit scan at count 1234.
        do_reset(2'b11);
        run(2468);
        check("scan1234 led", {24'd0, led}, 1234 % 256);
        read_display(1234, "scan1234");

        // BCD rollover 9999 -> 0000.
        do_reset(2'b11);
        run(19998);
        check("roll led pre", {24'd0, led}, 9999 % 256);
        read_display(9999, "roll9999");
        swt = 2'b11;
        w   = 0;
        while (led == 8'(9999 % 256) && w < 8) begin
            run(1);
            w++;
        end
        check("roll tick in bound", {31'd0, w < 8}, 32'd1);
        check("roll led post", {24'd0, led}, 10000 % 256);
        read_display(0, "roll0000");

        // Reset coinciding with a tick edge at led=7.
        do_reset(2'b11);
        run(15);
        check("midrst led before", {24'd0, led}, 32'd7);
        rst_n = 1'b0;
        run(1);
        check("midrst led", {24'd0, led}, 32'd0);
        check("midrst an",  {28'd0, an},  32'h0000_000E);
        check("midrst seg", {25'd0, seg}, 32'h0000_0040);
        rst_n = 1'b1;
        run(1);
        check("midrst edge1", {24'd0, led}, 32'd0);
        run(1);
        check("midrst edge2", {24'd0, led}, 32'd1);

        // Randomized switch changes and occasional resets, checked by the model.
        for (int it = 0; it < 800; it++) begin
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                swt   = 2'($urandom_range(0, 3));
                run(1);
                rst_n = 1'b1;
            end
            swt = 2'($urandom_range(0, 3));
            run($urandom_range(1, 60));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
